// File: rtl/chip_test_pkg.sv
// Shared types, DIP pin tables and gate truth function for the quad 2-input gate tester.
package chip_test_pkg;

    typedef enum logic [2:0] {
        GATE_NAND = 3'd0,
        GATE_NOR  = 3'd1,
        GATE_AND  = 3'd2,
        GATE_OR   = 3'd3,
        GATE_XOR  = 3'd4
    } gate_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } tester_state_e;

    localparam int NUM_GATES = 4;

    // Bit indices into the 14-bit pin buses (DIP pin n is bit n-1).
    localparam logic [3:0] STD_A_PIN [NUM_GATES] = '{4'd0, 4'd3, 4'd8,  4'd11};
    localparam logic [3:0] STD_B_PIN [NUM_GATES] = '{4'd1, 4'd4, 4'd9,  4'd12};
    localparam logic [3:0] STD_Y_PIN [NUM_GATES] = '{4'd2, 4'd5, 4'd7,  4'd10};
    localparam logic [3:0] NOR_A_PIN [NUM_GATES] = '{4'd1, 4'd4, 4'd7,  4'd10};
    localparam logic [3:0] NOR_B_PIN [NUM_GATES] = '{4'd2, 4'd5, 4'd8,  4'd11};
    localparam logic [3:0] NOR_Y_PIN [NUM_GATES] = '{4'd0, 4'd3, 4'd9,  4'd12};

    function automatic logic gate_supported(input logic [2:0] sel);
        return (sel <= 3'd4);
    endfunction

    function automatic logic gate_eval(input logic [2:0] sel, input logic a, input logic b);
        logic y;
        case (sel)
            GATE_NAND: y = ~(a & b);
            GATE_NOR:  y = ~(a | b);
            GATE_AND:  y = a & b;
            GATE_OR:   y = a | b;
            GATE_XOR:  y = a ^ b;
            default:   y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/quad2_pinmap.sv
// Maps four {A,B} gate stimulus pairs onto DIP pin drive buses for the selected chip type.
module quad2_pinmap
    import chip_test_pkg::*;
(
    input  logic [2:0]  sel_q,
    input  logic [7:0]  ab_pairs,   // gate g pair at [2g+1:2g], A in the upper bit
    output logic [13:0] pin_out,
    output logic [13:0] pin_oe,
    output logic [15:0] y_idx       // gate g Y pin index at [4g+3:4g]
);

    logic       is_nor;
    logic       is_valid;
    logic [3:0] a_pin [NUM_GATES];
    logic [3:0] b_pin [NUM_GATES];

    assign is_nor   = (sel_q == GATE_NOR);
    assign is_valid = gate_supported(sel_q);

    generate
        for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_pins
            assign a_pin[gi]          = is_nor ? NOR_A_PIN[gi] : STD_A_PIN[gi];
            assign b_pin[gi]          = is_nor ? NOR_B_PIN[gi] : STD_B_PIN[gi];
            assign y_idx[gi*4 +: 4]   = is_nor ? NOR_Y_PIN[gi] : STD_Y_PIN[gi];
        end
    endgenerate

    // Only A/B pins are ever enabled; Y and supply pins stay high-Z by construction.
    always_comb begin
        pin_out = '0;
        pin_oe  = '0;
        if (is_valid) begin
            for (int g = 0; g < NUM_GATES; g++) begin
                pin_out[a_pin[g]] = ab_pairs[2*g+1];
                pin_out[b_pin[g]] = ab_pairs[2*g];
                pin_oe[a_pin[g]]  = 1'b1;
                pin_oe[b_pin[g]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip_quad2_tester.sv
// Per-chip test engine: applies four stimulus vectors to a quad 2-input gate DIP and
// checks every gate output against its expected function.
module chip_quad2_tester
    import chip_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_VECTORS   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic [2:0]  gate_sel,
    input  logic [13:0] pin_in,
    output logic [13:0] pin_out,
    output logic [13:0] pin_oe,
    output logic        Done,
    output logic        RSLT,
    output logic [3:0]  fail_mask,
    output logic [1:0]  vec_idx
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_DRIVE  = ST_DRIVE;
    localparam logic [2:0] S_SETTLE = ST_SETTLE;
    localparam logic [2:0] S_SAMPLE = ST_SAMPLE;
    localparam logic [2:0] S_DONE   = ST_DONE;

    logic [2:0]  state_reg;
    logic [2:0]  sel_q;
    logic [7:0]  settle_cnt_reg;
    logic [13:0] sync1_reg;
    logic [13:0] sync2_reg;

    logic [7:0]  ab_pairs;
    logic [13:0] map_pin_out;
    logic [13:0] map_pin_oe;
    logic [15:0] y_idx;
    logic [3:0]  exp_y;
    logic [3:0]  mismatch;
    logic [3:0]  fail_next;
    logic        last_vec;

    // Rotating the pair by gate index gives every vector all four input combinations.
    generate
        for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
            assign ab_pairs[2*gi +: 2] = vec_idx + 2'(gi);
            assign exp_y[gi]           = gate_eval(sel_q, ab_pairs[2*gi+1], ab_pairs[2*gi]);
            assign mismatch[gi]        = (sync2_reg[y_idx[gi*4 +: 4]] != exp_y[gi]);
        end
    endgenerate

    assign fail_next = fail_mask | mismatch;
    assign last_vec  = (vec_idx == 2'(NUM_VECTORS - 1));
    assign Done      = (state_reg == S_DONE);

    quad2_pinmap u_pinmap (
        .sel_q    (sel_q),
        .ab_pairs (ab_pairs),
        .pin_out  (map_pin_out),
        .pin_oe   (map_pin_oe),
        .y_idx    (y_idx)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= S_IDLE;
            sel_q          <= '0;
            settle_cnt_reg <= '0;
            sync1_reg      <= '0;
            sync2_reg      <= '0;
            pin_out        <= '0;
            pin_oe         <= '0;
            RSLT           <= 1'b0;
            fail_mask      <= '0;
            vec_idx        <= '0;
        end else begin
            // pin_in is asynchronous to Clk; SETTLE_CYCLES >= 3 covers this latency.
            sync1_reg <= pin_in;
            sync2_reg <= sync1_reg;

            case (state_reg)
                S_IDLE: begin
                    pin_oe <= '0;
                    if (Run) begin
                        sel_q <= gate_sel;
                        if (!gate_supported(gate_sel)) begin
                            RSLT      <= 1'b0;
                            fail_mask <= 4'hF;
                            state_reg <= S_DONE;
                        end else begin
                            RSLT      <= 1'b0;
                            fail_mask <= '0;
                            vec_idx   <= '0;
                            state_reg <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    pin_out        <= map_pin_out;
                    pin_oe         <= map_pin_oe;
                    settle_cnt_reg <= 8'(SETTLE_CYCLES - 1);
                    state_reg      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_reg == 8'd0) begin
                        state_reg <= S_SAMPLE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    fail_mask <= fail_next;
                    if (last_vec) begin
                        pin_oe    <= '0;
                        pin_out   <= '0;
                        RSLT      <= (fail_next == 4'd0);
                        state_reg <= S_DONE;
                    end else begin
                        vec_idx   <= vec_idx + 2'd1;
                        state_reg <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    pin_oe <= '0;
                    if (!Run) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    pin_oe    <= '0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip_quad2_tester.sv
// Scoreboard bench for chip_quad2_tester with a behavioural DIP model on the pin buses.
module tb_chip_quad2_tester;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic [2:0]  gate_sel;
    logic [13:0] pin_in;
    logic [13:0] pin_out;
    logic [13:0] pin_oe;
    logic        Done;
    logic        RSLT;
    logic [3:0]  fail_mask;
    logic [1:0]  vec_idx;

    always #5 Clk = ~Clk;

    chip_quad2_tester #(.SETTLE_CYCLES(4), .NUM_VECTORS(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .gate_sel  (gate_sel),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .Done      (Done),
        .RSLT      (RSLT),
        .fail_mask (fail_mask),
        .vec_idx   (vec_idx)
    );

    localparam logic [13:0] STD_FORBID = 14'h24E4;  // pins 3,6,7,8,11,14
    localparam logic [13:0] NOR_FORBID = 14'h3249;  // pins 1,4,7,10,13,14
    localparam logic [13:0] STD_DRIVE  = 14'h1B1B;  // pins 1,2,4,5,9,10,12,13

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Chip model: 0..4 = 7400/7402/7408/7432/7486, -1 = empty socket
    int          model_type = 0;
    logic [13:0] stuck0     = '0;
    logic        g4_and     = 1'b0;
    logic [13:0] forbid_oe  = STD_FORBID;
    logic [13:0] drv;
    logic [13:0] pin_model;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic chip_fn(input int t, input logic a, input logic b);
        case (t)
            0:       return ~(a & b);
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        drv       = pin_oe & pin_out;
        pin_model = drv;
        if (model_type == 1) begin
            pin_model[0]  = ~(drv[1]  | drv[2]);
            pin_model[3]  = ~(drv[4]  | drv[5]);
            pin_model[9]  = ~(drv[7]  | drv[8]);
            pin_model[12] = ~(drv[10] | drv[11]);
        end else if (model_type >= 0) begin
            pin_model[2]  = chip_fn(model_type, drv[0], drv[1]);
            pin_model[5]  = chip_fn(model_type, drv[3], drv[4]);
            pin_model[7]  = chip_fn(model_type, drv[8], drv[9]);
            pin_model[10] = g4_and ? (drv[11] & drv[12]) : chip_fn(model_type, drv[11], drv[12]);
        end
        pin_in = pin_model & ~stuck0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rslt;
        logic [3:0] mask;
        int         lat;
        int         start;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    logic done_prev = 1'b0;

    // Monitor: forbidden-pin watch every cycle, scoreboard pop on each Done rise.
    always @(negedge Clk) begin
        exp_t e;
        check("pin_oe_forbidden", 32'(pin_oe & forbid_oe), 32'd0);
        if (Done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_rslt"},    32'(RSLT),      32'(e.rslt));
                check({e.name, "_mask"},    32'(fail_mask), 32'(e.mask));
                check({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
                $display("test %s: RSLT=%0b fail_mask=%04b latency=%0d", e.name, RSLT, fail_mask, cyc - e.start);
            end
        end
        done_prev = Done;
    end

    task automatic start_test(input string name, input logic [2:0] sel,
                              input logic exp_r, input logic [3:0] exp_m, input int lat);
        exp_t e;
        e.rslt  = exp_r;
        e.mask  = exp_m;
        e.lat   = lat;
        e.start = cyc;
        e.name  = name;
        sb_q.push_back(e);
        gate_sel = sel;
        Run      = 1'b1;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (Done) break;
        end
        check({name, "_done_reached"}, 32'(Done), 32'd1);
    endtask

    task automatic finish_test(input string name);
        Run = 1'b0;
        @(negedge Clk);
        check({name, "_done_cleared"}, 32'(Done), 32'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        Run      = 1'b0;
        gate_sel = 3'd0;
        repeat (3) @(negedge Clk);
        check("reset_pin_oe",    32'(pin_oe),    32'd0);
        check("reset_pin_out",   32'(pin_out),   32'd0);
        check("reset_done",      32'(Done),      32'd0);
        check("reset_rslt",      32'(RSLT),      32'd0);
        check("reset_fail_mask", 32'(fail_mask), 32'd0);
        check("reset_vec_idx",   32'(vec_idx),   32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Good 7400
        model_type = 0; forbid_oe = STD_FORBID;
        start_test("nand_good", 3'd0, 1'b1, 4'h0, 25);
        wait_done("nand_good");
        finish_test("nand_good");

        // 7402 with an input pin stuck low, then its G1 output stuck low
        model_type = 1; forbid_oe = NOR_FORBID; stuck0 = 14'h0004;
        start_test("nor_pin3_stuck", 3'd1, 1'b1, 4'h0, 25);
        wait_done("nor_pin3_stuck");
        finish_test("nor_pin3_stuck");
        stuck0 = 14'h0001;
        start_test("nor_pin1_stuck", 3'd1, 1'b0, 4'b0001, 25);
        wait_done("nor_pin1_stuck");
        finish_test("nor_pin1_stuck");

        // 7486 with G4 behaving as AND; fails in vector 0 where G4 sees {1,1}
        model_type = 4; forbid_oe = STD_FORBID; stuck0 = '0; g4_and = 1'b1;
        start_test("xor_g4_bad", 3'd4, 1'b0, 4'b1000, 25);
        repeat (7) @(negedge Clk);
        check("xor_g4_mask_after_v0", 32'(fail_mask), 32'h8);
        check("xor_g4_vec_after_v0",  32'(vec_idx),   32'd1);
        wait_done("xor_g4_bad");
        repeat (5) @(negedge Clk);
        check("hold_run_done_stays", 32'(Done),   32'd1);
        check("hold_run_no_drive",   32'(pin_oe), 32'd0);
        finish_test("xor_g4_bad");
        check("rslt_kept_in_idle", 32'(RSLT),      32'd0);
        check("mask_kept_in_idle", 32'(fail_mask), 32'h8);

        // Good 7408; gate_sel changed mid-test must not matter
        model_type = 2; g4_and = 1'b0;
        start_test("and_sel_change", 3'd2, 1'b1, 4'h0, 25);
        repeat (2) @(negedge Clk);
        check("mask_cleared_at_start", 32'(fail_mask), 32'd0);
        gate_sel = 3'd6;
        wait_done("and_sel_change");
        finish_test("and_sel_change");

        // Good 7432
        model_type = 3;
        start_test("or_good", 3'd3, 1'b1, 4'h0, 25);
        wait_done("or_good");
        finish_test("or_good");

        // Unsupported selection: immediate fail, never drives
        model_type = -1; forbid_oe = 14'h3FFF;
        start_test("unsupported", 3'd6, 1'b0, 4'hF, 1);
        wait_done("unsupported");
        finish_test("unsupported");

        // Reset during SETTLE of vector 2, then a complete test
        model_type = 0; forbid_oe = STD_FORBID;
        gate_sel = 3'd0;
        Run      = 1'b1;
        repeat (15) @(negedge Clk);
        check("pre_reset_vec_idx", 32'(vec_idx), 32'd2);
        check("pre_reset_pin_oe",  32'(pin_oe),  32'(STD_DRIVE));
        #1 Reset = 1'b1;
        #1;
        check("async_reset_pin_oe",  32'(pin_oe),  32'd0);
        check("async_reset_done",    32'(Done),    32'd0);
        check("async_reset_vec_idx", 32'(vec_idx), 32'd0);
        Run = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        start_test("after_reset", 3'd0, 1'b1, 4'h0, 25);
        wait_done("after_reset");
        finish_test("after_reset");

        repeat (2) @(negedge Clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
